unified_mod_mul: RTL and testbench
==================================

# unified_mod_mul

Pipelined modular multiplier that sits directly upstream of the unified Kyber/Dilithium modular adder in the butterfly datapath. It produces the twiddle product (a·w mod q) and delays the untouched butterfly operand by the same amount, so both arrive at the adder aligned. It runs in two modes. Mode 0 is dual-lane Kyber: two independent 12-bit lanes mod 3329, packed {hi,lo} into 24 bits. Mode 1 is single-lane Dilithium: 23-bit operands mod 8380417 in a 24-bit word.

## Interface
- LAT, 4: fixed pipeline depth in cycles, from input capture to output valid.
- KQ, 3329: Kyber modulus.
- DQ, 8380417: Dilithium modulus.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  pipeline advance; when 0, every stage register holds.
- in_valid  in  1  qualifies the inputs on a cycle with en=1.
- mode  in  1  0 = dual 12-bit Kyber, 1 = 24-bit Dilithium; captured per operand.
- mul_a  in  24  multiplicand; mode 0 is {a_hi[11:0], a_lo[11:0]}, mode 1 uses [22:0] with [23]=0.
- mul_w  in  24  twiddle, packed the same way as mul_a.
- byp  in  24  butterfly operand, passed through unchanged.
- out_valid  out  1  product valid.
- out_mode  out  1  mode of the operand on the output.
- prod  out  24  a·w mod q; canonical, so each lane is strictly less than its modulus.
- byp_out  out  24  byp delayed by LAT.

## Operation
- Inputs must be canonical: each Kyber lane < 3329, Dilithium word < 8380417. Non-canonical input is not driven and its result is undefined.
- Stage 1: register the full products.
  - Mode 0: two 24-bit products, p_hi = a_hi·w_hi and p_lo = a_lo·w_lo.
  - Mode 1: one 46-bit product.
- Stage 2: Barrett quotient estimate t = (p·m) >> k.
  - Kyber: m = 5039 = floor(2^24/3329), k = 24.
  - Dilithium: m = floor(2^46/8380417), k = 46.
- Stage 3: r = p − t·q, kept with at least 2 bits of headroom above the modulus width (14 bits for Kyber, 25 bits for Dilithium).
- Stage 4: up to two conditional subtractions of q, giving a canonical result; repack as {r_hi,r_lo} in mode 0 or {1'b0,r[22:0]} in mode 1.
- Mode, valid and byp travel in a shift register alongside the data, one entry per stage. A mode change between consecutive operands needs no bubble.
- The unused datapath width in each mode is don't-care internally. prod[23] must be 0 in mode 1.
- en=0 freezes all stages, including valid, mode and byp. No data is lost or duplicated.

## Timing
- Reset (rst low, async) values: out_valid=0, out_mode=0, prod=0, byp_out=0, all stage valids=0.
  - Data registers may also reset to 0.
  - Reset asserted mid-operation discards every in-flight operand.
  - Outputs go to 0 immediately, without waiting for a clock edge.
- Latency: an operand captured at edge N (en=1, in_valid=1) appears on prod/byp_out with out_valid=1 after edge N+4, counting only edges where en=1.
- Throughput: one operand per enabled cycle, with no back-pressure other than en.
- in_valid=0 inserts a bubble; out_valid=0 exactly 4 enabled cycles later.
- Outputs are registered, with no combinational path from inputs to outputs.
- First capture after reset deassertion: the first rising edge at which rst is high.

## Test plan
- Kyber corner: mode 0, a=w={3328,3328} → prod={1,1}, out_valid exactly 4 cycles later.
- Kyber mixed lanes: a={1234,17}, w={5,2} → prod={2841,34}; byp=24'hABCDEF → byp_out=24'hABCDEF in the same cycle.
- Dilithium:
  - a=w=8380416 → prod=1.
  - a=4194304, w=2 → prod=8191.
  - a=0, w=8380416 → prod=0.
- Back-to-back mode switching: alternate mode 0 and mode 1 operands on every cycle, with random canonical operands for 1000 cycles, checked against a golden model. out_mode must track each operand, with no bubbles.
- Stall: hold en=0 for 3 cycles while 2 operands are in flight → outputs and out_valid frozen; after en returns, results emerge in order with latency of 4 enabled cycles.
- Reset mid-stream: assert rst low while 4 operands are in flight → out_valid=0 and prod=0 immediately. After release, no stale operand emerges, and a new operand gives correct output 4 cycles later.

Source files
------------

// File: rtl/unified_mod_mul.sv
// Five-register modular multiplier feeding the butterfly adder: dual 12-bit lanes mod KQ
// or one 23-bit word mod DQ, Barrett-reduced, with the bypass operand delayed alongside.
module unified_mod_mul #(
    parameter int KQ = 3329,
    parameter int DQ = 8380417
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        in_valid,
    input  logic        mode,
    input  logic [23:0] mul_a,
    input  logic [23:0] mul_w,
    input  logic [23:0] byp,
    output logic        out_valid,
    output logic        out_mode,
    output logic [23:0] prod,
    output logic [23:0] byp_out
);

    localparam int LAT = 4;
    localparam int KM  = (1 << 24) / KQ;
    localparam longint unsigned DM_W = (64'd1 << 46) / 64'(DQ);

    localparam logic [12:0] KQ_C = 13'(KQ);
    localparam logic [12:0] KM_C = 13'(KM);
    localparam logic [22:0] DQ_C = 23'(DQ);
    localparam logic [23:0] DM_C = 24'(DM_W);

    // Side channel: index 0 is the input capture stage, index LAT drives the outputs.
    logic [LAT:0] vld_q, vld_d;
    logic [LAT:0] mode_q, mode_d;
    logic [23:0]  byp_q [LAT+1];
    logic [23:0]  byp_d [LAT+1];

    logic [23:0] a0_q, a0_d, w0_q, w0_d;
    logic [47:0] p1_q, p1_d;
    logic [27:0] p2_q, p2_d;
    logic [25:0] t2_q, t2_d;
    logic [27:0] r3_q, r3_d;
    logic [23:0] prod_q, prod_d;

    function automatic logic [13:0] red_k(input logic [13:0] x);
        logic [13:0] y;
        y = x;
        if (y >= 14'(KQ_C)) y = y - 14'(KQ_C);
        if (y >= 14'(KQ_C)) y = y - 14'(KQ_C);
        return y;
    endfunction

    function automatic logic [24:0] red_d(input logic [24:0] x);
        logic [24:0] y;
        y = x;
        if (y >= 25'(DQ_C)) y = y - 25'(DQ_C);
        if (y >= 25'(DQ_C)) y = y - 25'(DQ_C);
        return y;
    endfunction

    always_comb begin
        vld_d    = {vld_q[LAT-1:0], in_valid};
        mode_d   = {mode_q[LAT-1:0], mode};
        byp_d[0] = byp;
        for (int i = 1; i <= LAT; i++) begin
            byp_d[i] = byp_q[i-1];
        end

        a0_d = mul_a;
        w0_d = mul_w;

        // Each stage decodes its data with the mode of the operand it is consuming.
        if (mode_q[0]) begin
            p1_d = {2'b00, 46'(a0_q[22:0]) * 46'(w0_q[22:0])};
        end else begin
            p1_d = {24'(a0_q[23:12]) * 24'(w0_q[23:12]),
                    24'(a0_q[11:0])  * 24'(w0_q[11:0])};
        end

        if (mode_q[1]) begin
            t2_d = {2'b00, 24'((70'(p1_q[45:0]) * 70'(DM_C)) >> 46)};
            p2_d = {3'b000, p1_q[24:0]};
        end else begin
            t2_d = {13'((37'(p1_q[47:24]) * 37'(KM_C)) >> 24),
                    13'((37'(p1_q[23:0])  * 37'(KM_C)) >> 24)};
            p2_d = {p1_q[37:24], p1_q[13:0]};
        end

        // Only the low bits of p and t*q are needed: the true remainder is below 3q.
        if (mode_q[2]) begin
            r3_d = {3'b000, p2_q[24:0] - 25'(48'(t2_q[23:0]) * 48'(DQ_C))};
        end else begin
            r3_d = {p2_q[27:14] - 14'(26'(t2_q[25:13]) * 26'(KQ_C)),
                    p2_q[13:0]  - 14'(26'(t2_q[12:0])  * 26'(KQ_C))};
        end

        if (mode_q[3]) begin
            prod_d = {1'b0, 23'(red_d(r3_q[24:0]))};
        end else begin
            prod_d = {12'(red_k(r3_q[27:14])), 12'(red_k(r3_q[13:0]))};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= '0;
            mode_q <= '0;
            byp_q  <= '{default: '0};
            a0_q   <= '0;
            w0_q   <= '0;
            p1_q   <= '0;
            p2_q   <= '0;
            t2_q   <= '0;
            r3_q   <= '0;
            prod_q <= '0;
        end else if (en) begin
            vld_q  <= vld_d;
            mode_q <= mode_d;
            byp_q  <= byp_d;
            a0_q   <= a0_d;
            w0_q   <= w0_d;
            p1_q   <= p1_d;
            p2_q   <= p2_d;
            t2_q   <= t2_d;
            r3_q   <= r3_d;
            prod_q <= prod_d;
        end
    end

    assign out_valid = vld_q[LAT];
    assign out_mode  = mode_q[LAT];
    assign prod      = prod_q;
    assign byp_out   = byp_q[LAT];

endmodule

// File: tb/tb_unified_mod_mul.sv
// Self-checking bench for unified_mod_mul: directed vectors, stall/reset sequences and
// random traffic compared against a delay-line model using plain modular arithmetic.
module tb_unified_mod_mul;

    localparam int LAT = 4;
    localparam int KQ  = 3329;
    localparam int DQ  = 8380417;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        in_valid = 1'b0;
    logic        mode = 1'b0;
    logic [23:0] mul_a = '0;
    logic [23:0] mul_w = '0;
    logic [23:0] byp = '0;
    logic        out_valid;
    logic        out_mode;
    logic [23:0] prod;
    logic [23:0] byp_out;

    always #5 clk = ~clk;

    unified_mod_mul #(.KQ(KQ), .DQ(DQ)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .mode(mode),
        .mul_a(mul_a), .mul_w(mul_w), .byp(byp),
        .out_valid(out_valid), .out_mode(out_mode), .prod(prod), .byp_out(byp_out)
    );

    typedef struct {
        logic        v;
        logic        md;
        logic [23:0] p;
        logic [23:0] b;
    } exp_t;

    typedef struct {
        logic        md;
        logic [23:0] a;
        logic [23:0] w;
        logic [23:0] b;
        logic [23:0] exp_p;
    } vec_t;

    exp_t pipe [LAT+1];
    vec_t vecs [7];
    int checks = 0;
    int errors = 0;

    function automatic logic [23:0] ref_mul(input logic md, input logic [23:0] a, input logic [23:0] w);
        longint unsigned x, y, hi, lo;
        if (md) begin
            x = a[22:0];
            y = w[22:0];
            return {1'b0, 23'((x * y) % DQ)};
        end
        x  = a[23:12];
        y  = w[23:12];
        hi = (x * y) % KQ;
        x  = a[11:0];
        y  = w[11:0];
        lo = (x * y) % KQ;
        return {12'(hi), 12'(lo)};
    endfunction

    function automatic logic [23:0] rand_op(input logic md);
        if (md) return 24'($urandom_range(0, DQ - 1));
        return {12'($urandom_range(0, KQ - 1)), 12'($urandom_range(0, KQ - 1))};
    endfunction

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i <= LAT; i++) pipe[i] = '{v: 1'b0, md: 1'b0, p: 24'd0, b: 24'd0};
    endtask

    // One clock: drive on the falling edge, update the model at the rising edge, compare 1ns later.
    task automatic step(input string tag, input logic e, input logic iv, input logic md,
                        input logic [23:0] a, input logic [23:0] w, input logic [23:0] b);
        @(negedge clk);
        en = e; in_valid = iv; mode = md; mul_a = a; mul_w = w; byp = b;
        @(posedge clk);
        if (e) begin
            for (int i = LAT; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = '{v: iv, md: md, p: ref_mul(md, a, w), b: b};
        end
        #1;
        check({tag, "_valid"}, 24'(out_valid), 24'(pipe[LAT].v));
        if (pipe[LAT].v) begin
            check({tag, "_mode"}, 24'(out_mode), 24'(pipe[LAT].md));
            check({tag, "_prod"}, prod, pipe[LAT].p);
            check({tag, "_byp"}, byp_out, pipe[LAT].b);
        end
        $display("%s: en=%0b iv=%0b mode=%0b a=%h w=%h -> out_valid=%0b prod=%h byp_out=%h",
                 tag, e, iv, md, a, w, out_valid, prod, byp_out);
    endtask

    task automatic bubble(input string tag);
        step(tag, 1'b1, 1'b0, 1'b0, 24'd0, 24'd0, 24'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out_valid"}, 24'(out_valid), 24'd0);
        check({tag, "_out_mode"}, 24'(out_mode), 24'd0);
        check({tag, "_prod"}, prod, 24'd0);
        check({tag, "_byp_out"}, byp_out, 24'd0);
    endtask

    initial begin
        logic        md, sv;
        logic [23:0] a, w, sp, sb, ea, eb;

        vecs[0] = '{md: 1'b0, a: {12'd3328, 12'd3328}, w: {12'd3328, 12'd3328}, b: 24'h123456, exp_p: {12'd1, 12'd1}};
        vecs[1] = '{md: 1'b0, a: {12'd1234, 12'd17}, w: {12'd5, 12'd2}, b: 24'hABCDEF, exp_p: {12'd2841, 12'd34}};
        vecs[2] = '{md: 1'b1, a: 24'd8380416, w: 24'd8380416, b: 24'h000001, exp_p: 24'd1};
        vecs[3] = '{md: 1'b1, a: 24'd4194304, w: 24'd2, b: 24'hFFFFFF, exp_p: 24'd8191};
        vecs[4] = '{md: 1'b1, a: 24'd0, w: 24'd8380416, b: 24'h5A5A5A, exp_p: 24'd0};
        vecs[5] = '{md: 1'b0, a: {12'd0, 12'd3328}, w: {12'd3328, 12'd1}, b: 24'h00F00F, exp_p: {12'd0, 12'd3328}};
        vecs[6] = '{md: 1'b1, a: 24'd1, w: 24'd8380416, b: 24'h765432, exp_p: 24'd8380416};

        model_clear();
        #2 rst = 1'b0;
        #1 check_zero_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        // Isolated vectors: result must appear exactly on the fourth enabled edge after capture.
        for (int i = 0; i < 7; i++) begin
            step("vec", 1'b1, 1'b1, vecs[i].md, vecs[i].a, vecs[i].w, vecs[i].b);
            for (int k = 1; k <= LAT; k++) begin
                bubble("vec_drain");
                if (k < LAT) check($sformatf("vec%0d_early_valid", i), 24'(out_valid), 24'd0);
            end
            check($sformatf("vec%0d_valid", i), 24'(out_valid), 24'd1);
            check($sformatf("vec%0d_mode", i), 24'(out_mode), 24'(vecs[i].md));
            check($sformatf("vec%0d_prod", i), prod, vecs[i].exp_p);
            check($sformatf("vec%0d_byp", i), byp_out, vecs[i].b);
        end

        // Alternating modes on every cycle, no bubbles.
        for (int i = 0; i < 1000; i++) begin
            md = (i % 2) == 1;
            step("alt", 1'b1, 1'b1, md, rand_op(md), rand_op(md), 24'($urandom()));
        end
        repeat (LAT + 1) bubble("alt_drain");

        // Random enable, valid and mode.
        for (int i = 0; i < 300; i++) begin
            md = 1'($urandom_range(0, 1));
            step("mix", ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), md,
                 rand_op(md), rand_op(md), 24'($urandom()));
        end
        repeat (LAT + 1) bubble("mix_drain");

        // Stall with A on the output and B one stage behind.
        a = rand_op(1'b0); w = rand_op(1'b0);
        ea = ref_mul(1'b0, a, w);
        step("stall_in", 1'b1, 1'b1, 1'b0, a, w, 24'h0A0A0A);
        a = rand_op(1'b1); w = rand_op(1'b1);
        eb = ref_mul(1'b1, a, w);
        step("stall_in", 1'b1, 1'b1, 1'b1, a, w, 24'h0B0B0B);
        repeat (3) bubble("stall_fill");
        check("stall_a_prod", prod, ea);
        sv = out_valid; sp = prod; sb = byp_out;
        for (int i = 0; i < 3; i++) begin
            md = 1'($urandom_range(0, 1));
            step("stall_hold", 1'b0, 1'b1, md, rand_op(md), rand_op(md), 24'($urandom()));
            check("stall_frozen_valid", 24'(out_valid), 24'(sv));
            check("stall_frozen_prod", prod, sp);
            check("stall_frozen_byp", byp_out, sb);
        end
        bubble("stall_resume");
        check("stall_b_valid", 24'(out_valid), 24'd1);
        check("stall_b_prod", prod, eb);
        check("stall_b_byp", byp_out, 24'h0B0B0B);
        repeat (LAT + 1) bubble("stall_drain");

        // Asynchronous reset with the pipeline full.
        for (int i = 0; i < 6; i++) begin
            md = (i % 2) == 0;
            step("rstmid_in", 1'b1, 1'b1, md, rand_op(md), rand_op(md), 24'($urandom() | 1));
        end
        check("rstmid_pre_valid", 24'(out_valid), 24'd1);
        #2;
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_zero_outputs("rstmid");
        model_clear();
        @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (LAT + 2) bubble("rstmid_stale");
        step("rstmid_new", 1'b1, 1'b1, 1'b0, vecs[1].a, vecs[1].w, vecs[1].b);
        repeat (LAT) bubble("rstmid_new_drain");
        check("rstmid_new_valid", 24'(out_valid), 24'd1);
        check("rstmid_new_prod", prod, vecs[1].exp_p);
        check("rstmid_new_byp", byp_out, vecs[1].b);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
